// File: rtl/jzjpcc_memory_access.sv
// Memory stage: issues data-memory requests, stalls upstream during wait states,
// extracts load data and registers the writeback record.
module jzjpcc_memory_access #(
    parameter int MEM_ADDR_MAX_B = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_result,
    input  logic        ex_mem_read_enable,
    input  logic        ex_mem_write_enable,
    input  logic [31:0] ex_mem_data_to_write,
    input  logic [3:0]  ex_mem_byte_mask,
    input  logic [2:0]  ex_funct3,
    input  logic [4:0]  ex_rd_addr,
    input  logic [1:0]  ex_rd_source,
    input  logic        ex_rd_write_enable,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_bmask,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd_addr,
    output logic        wb_rd_write_enable,
    output logic [31:0] wb_rd_data,
    output logic        fault,
    output logic [1:0]  fault_cause
);

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t      state;
    logic [7:0]  wait_count;

    logic        memop;
    logic        misaligned;
    logic        out_of_range;
    logic        static_fault;
    logic        timeout_hit;
    logic        req;
    logic        retire;
    logic        fault_now;
    logic [1:0]  cause_now;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] result_data;

    assign memop        = ex_valid & (ex_mem_read_enable | ex_mem_write_enable);
    assign out_of_range = |ex_alu_result[31:MEM_ADDR_MAX_B];
    assign static_fault = memop & (misaligned | out_of_range);
    assign timeout_hit  = (state == WAIT) && (wait_count == TIMEOUT_LIMIT);

    always_comb begin
        misaligned = 1'b0;
        if (ex_funct3[1:0] == 2'b01 && ex_alu_result[0]) begin
            misaligned = 1'b1;
        end
        if (ex_funct3[1:0] == 2'b10 && ex_alu_result[1:0] != 2'b00) begin
            misaligned = 1'b1;
        end
        if (ex_mem_read_enable && (ex_funct3 == 3'b011 || ex_funct3 == 3'b110 || ex_funct3 == 3'b111)) begin
            misaligned = 1'b1;
        end
        if (ex_mem_write_enable && ex_funct3[2]) begin
            misaligned = 1'b1;
        end
    end

    // The timeout cycle drops the request so the stage can retire the abort
    // and let upstream advance; a late ack in that cycle is therefore ignored.
    always_comb begin
        req = 1'b0;
        if (!reset) begin
            case (state)
                IDLE:    req = memop & ~static_fault;
                WAIT:    req = ~timeout_hit;
                default: req = 1'b0;
            endcase
        end
    end

    assign stall     = req & ~mem_ack;
    assign retire    = ex_valid & ~stall;
    assign mem_req   = req;
    assign mem_we    = req & ex_mem_write_enable;
    assign mem_addr  = req ? ex_alu_result[31:2] : 30'd0;
    assign mem_wdata = req ? ex_mem_data_to_write : 32'd0;
    assign mem_bmask = req ? ex_mem_byte_mask : 4'd0;

    always_comb begin
        fault_now = static_fault | timeout_hit;
        cause_now = 2'b00;
        if (timeout_hit) begin
            cause_now = 2'b11;
        end else if (static_fault) begin
            cause_now = misaligned ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        byte_sel = mem_rdata[{ex_alu_result[1:0], 3'b000} +: 8];
        half_sel = mem_rdata[{ex_alu_result[1], 4'b0000} +: 16];
        case (ex_funct3)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {24'd0, byte_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = mem_rdata;
        endcase
        result_data = (ex_rd_source == 2'b01) ? load_data : ex_alu_result;
    end

    // Request FSM plus the writeback register set, which only loads when the
    // stage is not stalling so each instruction retires exactly once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            wait_count         <= 8'd0;
            wb_valid           <= 1'b0;
            wb_rd_addr         <= 5'd0;
            wb_rd_write_enable <= 1'b0;
            wb_rd_data         <= 32'd0;
            fault              <= 1'b0;
            fault_cause        <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (req && !mem_ack) begin
                        state      <= WAIT;
                        wait_count <= 8'd1;
                    end
                end
                WAIT: begin
                    if (timeout_hit || mem_ack) begin
                        state      <= IDLE;
                        wait_count <= 8'd0;
                    end else begin
                        wait_count <= wait_count + 8'd1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    wait_count <= 8'd0;
                end
            endcase

            if (retire) begin
                wb_valid           <= 1'b1;
                wb_rd_addr         <= ex_rd_addr;
                wb_rd_write_enable <= ex_rd_write_enable & ~fault_now;
                wb_rd_data         <= result_data;
                fault              <= fault_now;
                fault_cause        <= cause_now;
            end else begin
                wb_valid    <= 1'b0;
                fault       <= 1'b0;
                fault_cause <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_jzjpcc_memory_access.sv
// Bench for the memory stage: directed vector table, randomized ops against a
// behavioural model, and hand-written reset/idle sequences.
module tb_jzjpcc_memory_access;

    localparam int T   = 4;
    localparam int MAB = 12;

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [1:0]  src;
        logic        rd_we;
        logic [4:0]  rd_addr;
        logic [31:0] wdata;
        logic [3:0]  bmask;
        logic [31:0] rdata;
        int          ack_delay;
    } op_t;

    typedef struct {
        logic        req;
        int          stalls;
        logic        fault;
        logic [1:0]  cause;
        logic        we;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        string name;
        op_t   op;
        exp_t  e;
    } vec_t;

    logic        clock;
    logic        reset;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic        ex_mem_read_enable;
    logic        ex_mem_write_enable;
    logic [31:0] ex_mem_data_to_write;
    logic [3:0]  ex_mem_byte_mask;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd_addr;
    logic [1:0]  ex_rd_source;
    logic        ex_rd_write_enable;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_bmask;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd_addr;
    logic        wb_rd_write_enable;
    logic [31:0] wb_rd_data;
    logic        fault;
    logic [1:0]  fault_cause;

    int n_vec  = 0;
    int n_miss = 0;

    jzjpcc_memory_access #(
        .MEM_ADDR_MAX_B(MAB),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ex_valid(ex_valid),
        .ex_alu_result(ex_alu_result),
        .ex_mem_read_enable(ex_mem_read_enable),
        .ex_mem_write_enable(ex_mem_write_enable),
        .ex_mem_data_to_write(ex_mem_data_to_write),
        .ex_mem_byte_mask(ex_mem_byte_mask),
        .ex_funct3(ex_funct3),
        .ex_rd_addr(ex_rd_addr),
        .ex_rd_source(ex_rd_source),
        .ex_rd_write_enable(ex_rd_write_enable),
        .stall(stall),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_bmask(mem_bmask),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .wb_valid(wb_valid),
        .wb_rd_addr(wb_rd_addr),
        .wb_rd_write_enable(wb_rd_write_enable),
        .wb_rd_data(wb_rd_data),
        .fault(fault),
        .fault_cause(fault_cause)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, want);
        end
    endtask

    function automatic op_t mk_op(input logic [31:0] addr, input logic rd, input logic wr,
                                  input logic [2:0] f3, input logic [1:0] src, input logic rd_we,
                                  input logic [4:0] rd_addr, input logic [31:0] wdata,
                                  input logic [3:0] bmask, input logic [31:0] rdata, input int ack_delay);
        op_t o;
        o.addr = addr; o.rd = rd; o.wr = wr; o.f3 = f3; o.src = src; o.rd_we = rd_we;
        o.rd_addr = rd_addr; o.wdata = wdata; o.bmask = bmask; o.rdata = rdata;
        o.ack_delay = ack_delay;
        return o;
    endfunction

    function automatic exp_t mk_exp(input logic req, input int stalls, input logic flt,
                                    input logic [1:0] cause, input logic we, input logic [31:0] data);
        exp_t e;
        e.req = req; e.stalls = stalls; e.fault = flt; e.cause = cause; e.we = we; e.data = data;
        return e;
    endfunction

    // Reference model: derives the outcome from the access rules with plain arithmetic.
    function automatic exp_t model(input op_t op);
        exp_t        e;
        logic        memop;
        logic        mis;
        logic        oor;
        int          off;
        logic [31:0] b;
        logic [31:0] h;
        logic [31:0] ld;
        memop = op.rd | op.wr;
        mis = 1'b0;
        if ((op.f3 % 4) == 1 && (op.addr % 2) != 0) mis = 1'b1;
        if ((op.f3 % 4) == 2 && (op.addr % 4) != 0) mis = 1'b1;
        if (op.rd && (op.f3 == 3 || op.f3 == 6 || op.f3 == 7)) mis = 1'b1;
        if (op.wr && op.f3 >= 4) mis = 1'b1;
        oor = longint'(op.addr) >= (longint'(1) << MAB);
        e.fault = memop && (mis || oor);
        e.cause = !e.fault ? 2'd0 : (mis ? 2'd1 : 2'd2);
        e.req = memop && !e.fault;
        e.stalls = 0;
        if (e.req) begin
            if (op.ack_delay < T) begin
                e.stalls = op.ack_delay;
            end else begin
                e.stalls = T;
                e.fault  = 1'b1;
                e.cause  = 2'd3;
            end
        end
        off = int'(op.addr % 4);
        b = (op.rdata >> (8 * off)) & 32'hFF;
        h = (op.rdata >> (16 * (off / 2))) & 32'hFFFF;
        case (op.f3)
            3'd0:    ld = (b >= 128) ? (b | 32'hFFFFFF00) : b;
            3'd1:    ld = (h >= 32768) ? (h | 32'hFFFF0000) : h;
            3'd4:    ld = b;
            3'd5:    ld = h;
            default: ld = op.rdata;
        endcase
        e.data = (op.src == 2'b01) ? ld : op.addr;
        e.we = op.rd_we && !e.fault;
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the retiring edge.
    task automatic applyStimulus(input string name, input op_t op, input exp_t e);
        int   stalls;
        logic done;
        logic req_want;
        ex_valid = 1'b1;
        ex_alu_result = op.addr;
        ex_mem_read_enable = op.rd;
        ex_mem_write_enable = op.wr;
        ex_mem_data_to_write = op.wdata;
        ex_mem_byte_mask = op.bmask;
        ex_funct3 = op.f3;
        ex_rd_addr = op.rd_addr;
        ex_rd_source = op.src;
        ex_rd_write_enable = op.rd_we;
        mem_rdata = op.rdata;
        stalls = 0;
        done = 1'b0;
        for (int k = 0; k < T + 3 && !done; k++) begin
            mem_ack = (k == op.ack_delay);
            @(negedge clock);
            req_want = e.req && !(e.cause == 2'd3 && k == T);
            checkOutput({name, " req"}, 32'(mem_req), 32'(req_want));
            if (req_want) begin
                checkOutput({name, " addr"}, 32'(mem_addr), op.addr >> 2);
                if (k == 0) begin
                    checkOutput({name, " we"}, 32'(mem_we), 32'(op.wr));
                    checkOutput({name, " wdata"}, mem_wdata, op.wdata);
                    checkOutput({name, " bmask"}, 32'(mem_bmask), 32'(op.bmask));
                end
            end else if (k == 0) begin
                checkOutput({name, " idle bus"}, {mem_we, mem_bmask, 27'(mem_addr | 30'(mem_wdata != 0))}, 32'd0);
            end
            if (stall) stalls++;
            else done = 1'b1;
            @(posedge clock);
            #1;
        end
        mem_ack = 1'b0;
        if (!done) begin
            n_vec++;
            n_miss++;
            $display("[TB] FAIL %s bound: stall still high after %0d cycles, want release", name, T + 3);
        end
        checkOutput({name, " stalls"}, 32'(stalls), 32'(e.stalls));
        checkOutput({name, " wb_valid"}, 32'(wb_valid), 32'd1);
        checkOutput({name, " wb_rd_addr"}, 32'(wb_rd_addr), 32'(op.rd_addr));
        checkOutput({name, " wb_we"}, 32'(wb_rd_write_enable), 32'(e.we));
        checkOutput({name, " fault"}, 32'(fault), 32'(e.fault));
        checkOutput({name, " cause"}, 32'(fault_cause), 32'(e.cause));
        if (!e.fault) checkOutput({name, " wb_data"}, wb_rd_data, e.data);
    endtask

    task automatic idle_cycle(input string name);
        ex_valid = 1'b0;
        ex_mem_read_enable = 1'b0;
        ex_mem_write_enable = 1'b0;
        @(posedge clock);
        #1;
        checkOutput({name, " wb_valid"}, 32'(wb_valid), 32'd0);
        checkOutput({name, " fault"}, 32'(fault), 32'd0);
    endtask

    vec_t vecs[$];

    initial begin
        op_t  op;
        exp_t e;
        int   kind;

        vecs.push_back('{"alu",      mk_op(32'h1234, 0, 0, 3'd0, 2'b00, 1, 5, 0, 0, 0, 99), mk_exp(0, 0, 0, 0, 1, 32'h1234)});
        vecs.push_back('{"alu ack",  mk_op(32'h55AA, 0, 0, 3'd0, 2'b00, 1, 7, 0, 0, 0, 0),  mk_exp(0, 0, 0, 0, 1, 32'h55AA)});
        vecs.push_back('{"lb",       mk_op(32'h103, 1, 0, 3'd0, 2'b01, 1, 6, 0, 0, 32'h80FF1234, 0), mk_exp(1, 0, 0, 0, 1, 32'hFFFFFF80)});
        vecs.push_back('{"lbu",      mk_op(32'h103, 1, 0, 3'd4, 2'b01, 1, 6, 0, 0, 32'h80FF1234, 0), mk_exp(1, 0, 0, 0, 1, 32'h00000080)});
        vecs.push_back('{"lhu",      mk_op(32'h102, 1, 0, 3'd5, 2'b01, 1, 8, 0, 0, 32'h80FF1234, 0), mk_exp(1, 0, 0, 0, 1, 32'h000080FF)});
        vecs.push_back('{"lh",       mk_op(32'h102, 1, 0, 3'd1, 2'b01, 1, 8, 0, 0, 32'h80FF1234, 0), mk_exp(1, 0, 0, 0, 1, 32'hFFFF80FF)});
        vecs.push_back('{"lb off1",  mk_op(32'h101, 1, 0, 3'd0, 2'b01, 1, 9, 0, 0, 32'h80FF1234, 0), mk_exp(1, 0, 0, 0, 1, 32'h00000012)});
        vecs.push_back('{"lw wait3", mk_op(32'h200, 1, 0, 3'd2, 2'b01, 1, 10, 0, 0, 32'hCAFEF00D, 3), mk_exp(1, 3, 0, 0, 1, 32'hCAFEF00D)});
        vecs.push_back('{"sw",       mk_op(32'h104, 0, 1, 3'd2, 2'b00, 0, 0, 32'hDEADBEEF, 4'hF, 0, 0), mk_exp(1, 0, 0, 0, 0, 32'h104)});
        vecs.push_back('{"sb wait1", mk_op(32'h3, 0, 1, 3'd0, 2'b00, 0, 0, 32'hAB000000, 4'h8, 0, 1), mk_exp(1, 1, 0, 0, 0, 32'h3)});
        vecs.push_back('{"lw mis",   mk_op(32'h102, 1, 0, 3'd2, 2'b01, 1, 11, 0, 0, 0, 0), mk_exp(0, 0, 1, 2'd1, 0, 0)});
        vecs.push_back('{"lw oor",   mk_op(32'h1000, 1, 0, 3'd2, 2'b01, 1, 12, 0, 0, 0, 0), mk_exp(0, 0, 1, 2'd2, 0, 0)});
        vecs.push_back('{"lw both",  mk_op(32'h1002, 1, 0, 3'd2, 2'b01, 1, 13, 0, 0, 0, 0), mk_exp(0, 0, 1, 2'd1, 0, 0)});
        vecs.push_back('{"ld",       mk_op(32'h0, 1, 0, 3'd3, 2'b01, 1, 14, 0, 0, 0, 0), mk_exp(0, 0, 1, 2'd1, 0, 0)});
        vecs.push_back('{"st f3=4",  mk_op(32'h0, 0, 1, 3'd4, 2'b00, 0, 0, 0, 4'h1, 0, 0), mk_exp(0, 0, 1, 2'd1, 0, 0)});
        vecs.push_back('{"lw top",   mk_op(32'hFFC, 1, 0, 3'd2, 2'b01, 1, 15, 0, 0, 32'h0BADF00D, 2), mk_exp(1, 2, 0, 0, 1, 32'h0BADF00D)});
        vecs.push_back('{"lw tmo",   mk_op(32'h300, 1, 0, 3'd2, 2'b01, 1, 16, 0, 0, 32'h11111111, 99), mk_exp(1, T, 1, 2'd3, 0, 0)});
        vecs.push_back('{"lw late",  mk_op(32'h300, 1, 0, 3'd2, 2'b01, 1, 17, 0, 0, 32'h22222222, T), mk_exp(1, T, 1, 2'd3, 0, 0)});
        vecs.push_back('{"lw last",  mk_op(32'h304, 1, 0, 3'd2, 2'b01, 1, 18, 0, 0, 32'h33333333, T - 1), mk_exp(1, T - 1, 0, 0, 1, 32'h33333333)});

        reset = 1'b1;
        mem_ack = 1'b0;
        mem_rdata = 32'd0;
        ex_valid = 1'b1;
        ex_alu_result = 32'h200;
        ex_mem_read_enable = 1'b1;
        ex_mem_write_enable = 1'b0;
        ex_mem_data_to_write = 32'd0;
        ex_mem_byte_mask = 4'd0;
        ex_funct3 = 3'd2;
        ex_rd_addr = 5'd3;
        ex_rd_source = 2'b01;
        ex_rd_write_enable = 1'b1;
        #12;
        checkOutput("reset mem_req", 32'(mem_req), 32'd0);
        checkOutput("reset stall", 32'(stall), 32'd0);
        checkOutput("reset wb", {wb_valid, wb_rd_write_enable, fault, fault_cause, wb_rd_addr}, 32'd0);
        checkOutput("reset wb_data", wb_rd_data, 32'd0);
        ex_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        foreach (vecs[i]) applyStimulus(vecs[i].name, vecs[i].op, vecs[i].e);

        // A fault record must last exactly one cycle.
        applyStimulus("mis again", vecs[10].op, vecs[10].e);
        idle_cycle("after fault");

        // Reset during WAIT abandons the access.
        ex_valid = 1'b1;
        ex_alu_result = 32'h300;
        ex_mem_read_enable = 1'b1;
        ex_mem_write_enable = 1'b0;
        ex_funct3 = 3'd2;
        ex_rd_source = 2'b01;
        mem_ack = 1'b0;
        @(negedge clock);
        checkOutput("pre-reset req", 32'(mem_req), 32'd1);
        @(posedge clock);
        #1;
        @(negedge clock);
        checkOutput("wait stall", 32'(stall), 32'd1);
        #1 reset = 1'b1;
        #1;
        checkOutput("rst-wait req", 32'(mem_req), 32'd0);
        checkOutput("rst-wait stall", 32'(stall), 32'd0);
        checkOutput("rst-wait wb", {wb_valid, fault}, 32'd0);
        ex_valid = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("rst-wait wb2", 32'(wb_valid), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        applyStimulus("post-rst alu", vecs[0].op, vecs[0].e);
        applyStimulus("post-rst lb", vecs[2].op, vecs[2].e);
        applyStimulus("post-rst tmo", vecs[16].op, vecs[16].e);

        for (int n = 0; n < 150; n++) begin
            kind = int'($urandom_range(0, 2));
            op.rd = (kind == 1);
            op.wr = (kind == 2);
            if ($urandom_range(0, 9) == 0) op.addr = $urandom;
            else op.addr = 32'($urandom_range(0, 32'h17FF));
            if ($urandom_range(0, 7) == 0) op.f3 = 3'($urandom_range(0, 7));
            else if (kind == 1) begin
                case ($urandom_range(0, 4))
                    0: op.f3 = 3'd0;
                    1: op.f3 = 3'd1;
                    2: op.f3 = 3'd2;
                    3: op.f3 = 3'd4;
                    default: op.f3 = 3'd5;
                endcase
            end else op.f3 = 3'($urandom_range(0, 2));
            op.src = (kind == 1) ? 2'b01 : 2'($urandom_range(0, 1) * 2);
            op.rd_we = 1'($urandom_range(0, 1));
            op.rd_addr = 5'($urandom_range(0, 31));
            op.wdata = $urandom;
            op.bmask = 4'($urandom_range(0, 15));
            op.rdata = $urandom;
            op.ack_delay = int'($urandom_range(0, T + 1));
            e = model(op);
            applyStimulus($sformatf("rand%0d", n), op, e);
            if ($urandom_range(0, 9) == 0) idle_cycle($sformatf("rand%0d idle", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
